// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores fill a small TX FIFO, and a baud-timed
// shift FSM sends each byte as 8N1, LSB first, on tx. Status and divisor are readable.
module io_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sig_w,
  input  logic        sig_r,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   baud_div;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    shift_q;
  logic [7:0]    shift_nxt;
  logic [15:0]   div_q;
  logic [15:0]   div_nxt;
  logic [15:0]   baud_cnt;
  logic [15:0]   baud_cnt_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_nxt;
  logic          tx_nxt;
  logic          pop;

  logic          wr_en;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_baud;
  logic          full;
  logic          empty;
  logic          push;
  logic          bit_end;
  logic          busy;
  logic [7:0]    count_byte;

  assign wr_en      = cs & sig_w;
  assign wr_txdata  = wr_en & (addr[3:2] == 2'd0);
  assign wr_status  = wr_en & (addr[3:2] == 2'd1);
  assign wr_baud    = wr_en & (addr[3:2] == 2'd2);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = wr_txdata & ~full;
  assign bit_end    = (baud_cnt == div_q - 16'd1);
  assign busy       = (state != IDLE);
  assign count_byte = 8'(count);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wdata[7:0];
    end
  end

  // A push into a full FIFO is dropped even when the FSM pops on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (wr_txdata & full) begin
        overflow <= 1'b1;
      end else if (wr_status & wdata[3]) begin
        overflow <= 1'b0;
      end
      if (wr_baud) begin
        baud_div <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      div_q    <= DEFAULT_DIV;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      shift_q  <= shift_nxt;
      div_q    <= div_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      tx       <= tx_nxt;
    end
  end

  // tx is registered from the current state, so the line lags the FSM by one clock.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_q;
    div_nxt      = div_q;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    tx_nxt       = 1'b1;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop          = 1'b1;
          shift_nxt    = fifo_mem[rd_ptr];
          div_nxt      = baud_div;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = DATA;
        end else begin
          baud_cnt_nxt = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        tx_nxt = shift_q[0];
        if (bit_end) begin
          baud_cnt_nxt = '0;
          shift_nxt    = {1'b0, shift_q[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (!empty) begin
            pop         = 1'b1;
            shift_nxt   = fifo_mem[rd_ptr];
            div_nxt     = baud_div;
            bit_idx_nxt = '0;
            state_nxt   = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    if (cs & sig_r) begin
      case (addr[3:2])
        2'd1:    rdata = {16'd0, count_byte, 4'd0, overflow, busy, empty, full};
        2'd2:    rdata = {16'd0, baud_div};
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Randomized scoreboard bench for io_uart_tx: a transaction-level model predicts each
// frame (byte, start cycle, clocks per bit) and a tx-line monitor checks it bit by bit.
module tb_io_uart_tx;

  localparam int DEPTH = 8;

  typedef struct {
    logic [7:0] data;
    int         start;
    int         div;
  } frame_t;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        sig_w;
  logic        sig_r;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;

  frame_t      sb[$];
  logic [7:0]  mdl_fifo[$];
  int          cyc;
  int          next_free;
  int          mdl_baud;
  bit          mdl_ovf;
  bit          mon_active;
  int          vectors;
  int          miscompares;

  io_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd868)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .sig_w(sig_w),
    .sig_r(sig_r),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .tx   (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a frame starts one clock after its pop, and a pop happens at the
  // first edge where the FIFO holds data and the previous frame's 10*div clocks are spent.
  initial begin
    cyc       = 0;
    next_free = 0;
    mdl_baud  = 868;
    mdl_ovf   = 1'b0;
    forever begin : model_step
      int     sz;
      frame_t f;
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        mdl_fifo.delete();
        sb.delete();
        mdl_ovf   = 1'b0;
        mdl_baud  = 868;
        next_free = 0;
      end else begin
        sz = mdl_fifo.size();
        if (sz > 0 && cyc >= next_free) begin
          f.data    = mdl_fifo.pop_front();
          f.start   = cyc + 1;
          f.div     = mdl_baud;
          sb.push_back(f);
          next_free = cyc + 10 * mdl_baud;
        end
        if (cs && sig_w) begin
          case (addr[3:2])
            2'd0: begin
              if (sz == DEPTH) mdl_ovf = 1'b1;
              else mdl_fifo.push_back(wdata[7:0]);
            end
            2'd1: if (wdata[3]) mdl_ovf = 1'b0;
            2'd2: mdl_baud = (wdata[15:0] < 16'd2) ? 2 : int'(wdata[15:0]);
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: checks every tx sample, either against the active frame or idle-high.
  initial begin
    frame_t     cur;
    int         errs;
    int         off;
    int         k;
    logic       exp_bit;
    logic [7:0] dec;
    mon_active = 1'b0;
    errs       = 0;
    dec        = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
      end else begin
        if (mon_active && cyc >= cur.start + 10 * cur.div) begin
          vectors++;
          if (errs != 0 || dec !== cur.data) begin
            miscompares++;
            $display("[TB] FAIL frame: got byte %02h with %0d bad bit-clocks, want byte %02h at %0d clks/bit starting cycle %0d",
                     dec, errs, cur.data, cur.div, cur.start);
          end
          mon_active = 1'b0;
        end
        if (!mon_active && sb.size() > 0 && sb[0].start == cyc) begin
          cur        = sb.pop_front();
          mon_active = 1'b1;
          errs       = 0;
          dec        = '0;
        end
        if (mon_active) begin
          off     = cyc - cur.start;
          k       = off / cur.div;
          exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : cur.data[k-1];
          if (tx !== exp_bit) errs++;
          if (k >= 1 && k <= 8 && (off % cur.div) == cur.div / 2) dec[k-1] = tx;
        end else begin
          vectors++;
          if (tx !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_tx: tx=%b at cycle %0d, want 1", tx, cyc);
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_status();
    return {16'd0, 8'(mdl_fifo.size()), 4'd0, mdl_ovf, (cyc < next_free),
            (mdl_fifo.size() == 0), (mdl_fifo.size() == DEPTH)};
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    cs    = 1'b1;
    sig_w = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    cs    = 1'b0;
    sig_w = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic checkOutput(input string name, input logic c, input logic r,
                             input logic [31:0] a, input logic [31:0] expv);
    cs    = c;
    sig_r = r;
    addr  = a;
    #1;
    vectors++;
    if (rdata !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: rdata=%08h, want %08h", name, rdata, expv);
    end
    cs    = 1'b0;
    sig_r = 1'b0;
    addr  = '0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (sb.size() == 0 && !mon_active && mdl_fifo.size() == 0 && cyc >= next_free) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL drain: queued frames=%0d, want 0 within 6000 cycles", sb.size());
    end
  endtask

  initial begin
    int r;
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    cs    = 1'b0;
    sig_w = 1'b0;
    sig_r = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_status", 1, 1, 32'h4, 32'h0000_0002);
    checkOutput("reset_baud", 1, 1, 32'h8, 32'd868);

    $display("[TB] single byte at 4 clks/bit");
    applyStimulus(32'h8, 32'd4);
    applyStimulus(32'h0, 32'h0000_00A5);
    repeat (5) begin
      repeat (7) @(negedge clk);
      checkOutput("status_during_frame", 1, 1, 32'h4, exp_status());
    end
    drain();
    checkOutput("status_after_frame", 1, 1, 32'h4, 32'h0000_0002);

    $display("[TB] back-to-back frames at 2 clks/bit");
    applyStimulus(32'h8, 32'd2);
    applyStimulus(32'h0, 32'h55);
    applyStimulus(32'h0, 32'h0F);
    checkOutput("count_after_first_pop", 1, 1, 32'h4, 32'h0000_0104);
    drain();

    $display("[TB] overflow with FIFO full");
    applyStimulus(32'h8, 32'd3);
    applyStimulus(32'h0, $urandom);
    repeat (2) @(negedge clk);
    repeat (9) applyStimulus(32'h0, $urandom);
    checkOutput("status_overflow", 1, 1, 32'h4, 32'h0000_080D);
    applyStimulus(32'h4, 32'h0000_0008);
    checkOutput("status_ovf_cleared", 1, 1, 32'h4, 32'h0000_0805);
    drain();

    $display("[TB] divisor clamp and mid-frame change");
    applyStimulus(32'h8, 32'd0);
    checkOutput("baud_clamp0", 1, 1, 32'h8, 32'd2);
    applyStimulus(32'h8, 32'd1);
    checkOutput("baud_clamp1", 1, 1, 32'h8, 32'd2);
    applyStimulus(32'h8, 32'hFFFF_0003);
    checkOutput("baud_upper_ignored", 1, 1, 32'h8, 32'd3);
    applyStimulus(32'h8, 32'd2);
    applyStimulus(32'h0, $urandom);
    repeat (5) @(negedge clk);
    applyStimulus(32'h8, 32'd6);
    applyStimulus(32'h0, $urandom);
    checkOutput("baud_mid_frame", 1, 1, 32'h8, 32'd6);
    drain();

    $display("[TB] read isolation");
    checkOutput("rd_no_sigr", 1, 0, 32'h4, 32'd0);
    checkOutput("rd_no_cs", 0, 1, 32'h8, 32'd0);
    checkOutput("rd_reserved", 1, 1, 32'hC, 32'd0);
    checkOutput("rd_txdata", 1, 1, 32'h0, 32'd0);
    checkOutput("rd_status_lowbits", 1, 1, 32'h7, exp_status());

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        applyStimulus(32'h0, $urandom);
      end else if (r == 6) begin
        applyStimulus(32'h8, $urandom_range(0, 5));
        checkOutput("rand_baud", 1, 1, 32'h8, 32'(mdl_baud));
      end else if (r == 7) begin
        checkOutput("rand_status", 1, 1, 32'h4 | 32'($urandom_range(0, 3)), exp_status());
      end else if (r == 8) begin
        applyStimulus(32'h4, $urandom);
        checkOutput("rand_status_wr", 1, 1, 32'h4, exp_status());
      end else begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end
    end
    drain();

    $display("[TB] reset mid-frame");
    applyStimulus(32'h8, 32'd5);
    applyStimulus(32'h0, 32'h3C);
    applyStimulus(32'h0, 32'hC3);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL tx_on_reset: tx=%b, want 1", tx);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("status_after_rst", 1, 1, 32'h4, 32'h0000_0002);
    checkOutput("baud_after_rst", 1, 1, 32'h8, 32'd868);
    applyStimulus(32'h8, 32'd2);
    applyStimulus(32'h0, $urandom);
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
Memory-mapped UART transmitter peripheral that responds to CPU loads and stores on the data-memory/IO bus. It sits beside the seg7 and switch peripherals and is selected by the IO address decoder. The CPU pushes bytes into a small TX FIFO and polls a status register. A baud generator and shift FSM serialise each byte as 8N1, LSB first, on pin tx.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of 2, 2..16.
DEFAULT_DIV, 16'd868, reset value of BAUDDIV in clk cycles per bit (100 MHz / 115200).

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
cs  in  1  peripheral select from IO decoder.
sig_w  in  1  store strobe; write commits at posedge clk when cs&sig_w.
sig_r  in  1  load strobe; read is combinational when cs&sig_r.
addr  in  32  byte address; only addr[3:2] decoded; addr[1:0] ignored.
wdata  in  32  store data (CPU Rt).
rdata  out  32  load data; 32'd0 when not (cs&sig_r).
tx  out  1  serial line, idle high, registered.

Behaviour:
- Register map (addr[3:2]):
  - 0 TXDATA: write pushes wdata[7:0]; reads 0.
  - 1 STATUS: read-only bits are [0] full, [1] empty, [2] busy (FSM not IDLE), [15:8] count. Bit [3] is overflow, sticky; writing 1 to bit [3] clears it, other bits ignored.
  - 2 BAUDDIV: R/W, [15:0]; written values below 2 are stored as 2; reads return the stored value zero-extended.
  - 3: reserved; reads 0, writes ignored.
- Reset values: tx=1, FIFO empty (count=0), overflow=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE, baud counter=0, bit index=0.
- rdata is purely combinational from current state; it does not include effects of a write in the same cycle.
- Push: when cs&sig_w&addr[3:2]==0.
  - If full before the edge, the byte is dropped and overflow is set, even if a pop occurs on the same edge.
  - Otherwise the byte is written at the tail.
- Pop: only the FSM pops, only when count>0 before the edge.
  - Simultaneous push+pop (not full) leaves count unchanged.
- FSM:
  - IDLE: tx=1. If count>0, pop the head into the shift register, latch BAUDDIV into div_q, clear the baud counter, go to START.
  - START: tx=0 for div_q cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for div_q cycles per bit; shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for div_q cycles.
    - At the end, if count>0, pop and go directly to START with a new div_q latch (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Baud counter counts 0..div_q-1; the bit boundary is at counter==div_q-1. A BAUDDIV write mid-frame affects only the next frame.
- Latency: a TXDATA write at edge N with the FSM idle and FIFO empty gives a pop at edge N+1, and tx falls after edge N+2.
- Frame length is exactly 10*div_q clocks.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Reset asserted mid-frame: tx returns to 1 immediately and all state returns to reset values; the frame is lost.

Test Plan:
- Reset: assert rst mid-simulation → tx=1, STATUS read=32'h00000002, BAUDDIV read=868.
- Single byte: BAUDDIV=4, write TXDATA=32'hA5 → tx low 4 clks starting 2 clks after the write; data bits 1,0,1,0,0,1,0,1 each 4 clks; stop high 4 clks; busy=1 throughout, then 0.
- Back-to-back: write 8'h55 and 8'h0F on consecutive cycles at BAUDDIV=2 → two contiguous 20-clk frames with no idle between; count read shows 1 right after the first pop.
- Overflow: with FSM busy, write 9 bytes with FIFO_DEPTH=8 → STATUS full=1, overflow=1, count=8; the 9th byte never transmitted; writing STATUS=32'h8 clears overflow only.
- BAUDDIV clamp and mid-frame change: write BAUDDIV=0 → reads 2. During a frame, write 6 → current frame stays at 2 clks/bit, next frame uses 6.
- Read isolation: sig_r=0 or cs=0 → rdata=0; reserved address → rdata=0; addr[1:0]=2'b11 with addr[3:2]=1 still reads STATUS.
